// File: rtl/frame_sync_if.sv
// frame_sync_if -- serial input and status outputs of the frame synchroniser.
// master: bit source / observer side. slave: the frame_sync block itself.
interface frame_sync_if;
    logic       bitstream;
    logic       bit_valid;
    logic       detect;
    logic       locked;
    logic [1:0] state;
    logic [2:0] frame_pos;
    logic [7:0] match_count;

    modport master (
        output bitstream, bit_valid,
        input  detect, locked, state, frame_pos, match_count
    );

    modport slave (
        input  bitstream, bit_valid,
        output detect, locked, state, frame_pos, match_count
    );
endinterface

// File: rtl/frame_sync.sv
// frame_sync -- serial frame marker detector with SEARCH/CHECK/LOCKED tracking.
// A marker must recur on consecutive frame boundaries LOCK_HITS times to lock;
// MISS_LIMIT consecutive boundary misses drop lock again.
// Optional build macro FRAME_SYNC_STATS_EN adds the saturating match_count of
// boundary matches seen while locked; without it match_count is tied to 0.
module frame_sync #(
    parameter logic [7:0]  PATTERN    = 8'b10001101,
    parameter int unsigned LOCK_HITS  = 2,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    frame_sync_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_HITS_W  = 4'(LOCK_HITS);
    localparam logic [3:0] MISS_LIMIT_W = 4'(MISS_LIMIT);

    state_t     state_q, state_d;
    // Only the seven most recent bits are kept; the eighth is the live input.
    logic [6:0] sr_q;
    logic [2:0] pos_q, pos_d;
    logic [3:0] hit_q, hit_d;
    logic [3:0] miss_q, miss_d;
    logic       detect_p1;
    logic       match;
    logic       boundary;

    // Marker compare on the incoming bit and frame-boundary qualifier.
    always_comb begin
        match    = bus.bit_valid && ({sr_q, bus.bitstream} == PATTERN);
        boundary = bus.bit_valid && (pos_q == 3'd7);
    end

    // History shift register, advanced only on consumed bits.
    always_ff @(posedge clk) begin
        if (rst)
            sr_q <= '0;
        else if (bus.bit_valid)
            sr_q <= {sr_q[5:0], bus.bitstream};
    end

    // Next-state logic: alignment search, confirmation and lock maintenance.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        if (bus.bit_valid) begin
            pos_d = pos_q + 3'd1;
            case (state_q)
                SEARCH: begin
                    if (match) begin
                        // Realign: the next consumed bit starts a new frame.
                        state_d = CHECK;
                        hit_d   = 4'd1;
                        pos_d   = 3'd0;
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        if (match) begin
                            hit_d = hit_q + 4'd1;
                            if (hit_q + 4'd1 == LOCK_HITS_W) begin
                                state_d = LOCKED;
                                miss_d  = 4'd0;
                            end
                        end else begin
                            state_d = SEARCH;
                            hit_d   = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (match) begin
                            miss_d = 4'd0;
                        end else if (miss_q + 4'd1 == MISS_LIMIT_W) begin
                            state_d = SEARCH;
                            miss_d  = 4'd0;
                            hit_d   = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    hit_d   = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

    // State, position and counter registers plus the registered detect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            pos_q     <= 3'd0;
            hit_q     <= 4'd0;
            miss_q    <= 4'd0;
            detect_p1 <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            detect_p1 <= match;
        end
    end

`ifdef FRAME_SYNC_STATS_EN
    logic [7:0] match_count_q;

    // Count boundary matches while locked, holding at 255.
    always_ff @(posedge clk) begin
        if (rst)
            match_count_q <= 8'd0;
        else if ((state_q == LOCKED) && boundary && match && (match_count_q != 8'hFF))
            match_count_q <= match_count_q + 8'd1;
    end

    assign bus.match_count = match_count_q;
`else
    assign bus.match_count = 8'd0;
`endif

    assign bus.detect    = detect_p1;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.state     = state_q;
    assign bus.frame_pos = pos_q;

endmodule
